// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder for 24-bit ID/address/data frames, backed by an 8-bit register bank.
// Optional error counter (err_cnt/err_clr) is built when SPI_SLAVE_ERR_CNT_EN is defined.
module spi_slave_regs #(
  parameter int          NUM_REGS = 16,
  parameter logic [7:0]  ID_WR    = 8'hFF,
  parameter logic [7:0]  ID_RD    = 8'h00
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_pulse,
  output logic       frame_done,
`ifdef SPI_SLAVE_ERR_CNT_EN
  input  logic       err_clr,
  output logic [7:0] err_cnt,
`endif
  output logic       frame_abort
);

  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_SKIP = 3'd4;
  localparam logic [2:0] ST_WAIT = 3'd5;

  // Synchronisers reset to 0 so a reset released mid-frame never fakes an ss fall.
  logic [1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic       ss_dly_q, sclk_dly_q;
  logic       ss_rise, ss_fall, sclk_rise, sclk_fall;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_dly_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ss_sync_q   <= {ss_sync_q[0], ss};
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      ss_dly_q    <= ss_sync_q[1];
      sclk_dly_q  <= sclk_sync_q[1];
    end
  end

  assign ss_rise   =  ss_sync_q[1] & ~ss_dly_q;
  assign ss_fall   = ~ss_sync_q[1] &  ss_dly_q;
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_dly_q;
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_dly_q;

  logic [2:0] state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       is_rd_q, is_rd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_pulse_q, rd_pulse_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic       wr_en;
  logic       frame_err;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       addr_in_range;
  logic [7:0] regs_q [NUM_REGS];

  assign rx_byte       = {shift_q, mosi_sync_q[1]};
  assign addr_in_range = {1'b0, addr_q} < NUM_REGS_W;
  assign rd_byte       = addr_in_range ? regs_q[addr_q[AW-1:0]] : 8'h00;
  assign host_rdata    = ({1'b0, host_addr} < NUM_REGS_W) ? regs_q[host_addr[AW-1:0]] : 8'h00;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en      = 1'b0;
    wr_pulse_d = 1'b0;
    rd_pulse_d = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    frame_err  = 1'b0;

    if (ss_sync_q[1]) bit_cnt_d = '0;

    if (ss_rise) begin
      // ss wins over any sclk edge detected in the same cycle.
      state_d = ST_IDLE;
      miso_d  = 1'b0;
      if (state_q != ST_IDLE) begin
        done_d    = (bit_cnt_q == 5'd24) && (state_q != ST_SKIP);
        abort_d   = (bit_cnt_q != 5'd0) && (bit_cnt_q < 5'd24);
        frame_err = abort_d || (state_q == ST_SKIP);
      end
    end else if (ss_fall && state_q == ST_IDLE) begin
      state_d   = ST_ID;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        if (bit_cnt_q < 5'd24) bit_cnt_d = bit_cnt_q + 5'd1;
        shift_d = rx_byte[6:0];
        case (state_q)
          ST_ID: if (bit_cnt_q == 5'd7) begin
            if (rx_byte == ID_WR) begin
              state_d = ST_ADDR;
              is_rd_d = 1'b0;
            end else if (rx_byte == ID_RD) begin
              state_d = ST_ADDR;
              is_rd_d = 1'b1;
            end else begin
              state_d = ST_SKIP;
            end
          end
          ST_ADDR: if (bit_cnt_q == 5'd15) begin
            addr_d     = rx_byte;
            rd_pulse_d = is_rd_q;
            state_d    = ST_DATA;
          end
          ST_DATA: if (bit_cnt_q == 5'd23) begin
            if (!is_rd_q && addr_in_range) begin
              wr_en      = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = rx_byte;
            end
            state_d = ST_WAIT;
          end
          default: ;
        endcase
      end else if (sclk_fall) begin
        miso_d = 1'b0;
        if (state_q == ST_DATA && is_rd_q) begin
          if (bit_cnt_q == 5'd16) begin
            miso_d = rd_byte[7];
            tx_d   = {rd_byte[6:0], 1'b0};
          end else begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_pulse_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_pulse_q <= rd_pulse_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      // NOTE: the bank is flops, not RAM, and the protocol requires it to read 0 after reset.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else if (wr_en) begin
      regs_q[addr_q[AW-1:0]] <= wr_data_d;
    end
  end

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)                             err_cnt_d = 8'h00;
    else if (frame_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) err_cnt_q <= 8'h00;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err;
  assign unused_err = frame_err;
`endif

  assign miso        = miso_q;
  assign wr_pulse    = wr_pulse_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_pulse    = rd_pulse_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule
